// File: rtl/reset_seq_pkg.sv
// Shared types, cause codes and parameter helpers for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      PAD  = 2'b10,
      LOCK = 2'b11
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_WDG  = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;

   // Widest packed hold vector the helper accepts (NUM_CH*HOLD_W must fit).
   localparam int HOLD_VEC_MAX = 256;

   // Extract hold count slice i (of width w) from a zero-extended hold vector.
   function automatic logic [31:0] hold_of(input logic [HOLD_VEC_MAX-1:0] vec,
                                           input int w, input int i);
      logic [HOLD_VEC_MAX-1:0] mask;
      mask = (HOLD_VEC_MAX'(1) << w) - HOLD_VEC_MAX'(1);
      return 32'((vec >> (i * w)) & mask);
   endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter; stops at zero and flags it.
module reset_seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         sys_res,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Count down toward zero; a load overrides the decrement.
   always_ff @(posedge clk) begin
      if (sys_res) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/reset_seq.sv
// N-channel reset sequencer with cause capture, watchdog-reset counting
// and escalation to a permanent core lockout.
//
// state | meaning
// IDLE  | no sequence running, waiting for wdg_to / sw_req
// HOLD  | channel active_ch held in reset for its hold count
// PAD   | all channels released between two consecutive holds
// LOCK  | too many watchdog resets; core held until sys_res
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int                         NUM_CH      = 2,
   parameter int                         HOLD_W      = 8,
   parameter logic [NUM_CH*HOLD_W-1:0]   HOLD_CYCLES = {8'd1, 8'd60},
   parameter int                         PAD_CYCLES  = 5,
   parameter int                         RCNT_W      = 4,
   parameter int                         MAX_RESETS  = 3,
   localparam int                        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              sys_res,
   input  logic              wdg_to,
   input  logic              sw_req,
   input  logic              clr_cnt,
   output logic [NUM_CH-1:0] ch_res_n,
   output logic              busy,
   output logic [CH_W-1:0]   active_ch,
   output logic [1:0]        reset_cause,
   output logic [RCNT_W-1:0] reset_cnt,
   output logic              lockout
);

   localparam int PAD_W  = $clog2(PAD_CYCLES + 1);
   localparam int TMR_W  = (HOLD_W > PAD_W) ? HOLD_W : PAD_W;
   localparam int PAD_LD = (PAD_CYCLES > 0) ? PAD_CYCLES - 1 : 0;
   localparam logic [HOLD_VEC_MAX-1:0] HOLD_EXT = HOLD_VEC_MAX'(HOLD_CYCLES);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   if (NUM_CH * HOLD_W > HOLD_VEC_MAX) begin : g_vec_chk
      $error("reset_seq: NUM_CH*HOLD_W exceeds HOLD_VEC_MAX");
   end
   if (MAX_RESETS >= (2 ** RCNT_W)) begin : g_max_chk
      $error("reset_seq: MAX_RESETS must be below 2**RCNT_W");
   end

   // Per-channel load values (hold-1); padded to a power of two so any
   // active_ch encoding indexes a defined entry.
   logic [TMR_W-1:0] hold_m1 [2**CH_W];

   for (genvar g = 0; g < 2**CH_W; g++) begin : g_hold
      if (g < NUM_CH) begin : g_used
         if (HOLD_CYCLES[g*HOLD_W +: HOLD_W] == '0) begin : g_zero_chk
            $error("reset_seq: hold count of channel %0d is zero", g);
         end
         assign hold_m1[g] = TMR_W'(hold_of(HOLD_EXT, HOLD_W, g) - 32'd1);
      end else begin : g_unused
         assign hold_m1[g] = '0;
      end
   end

   state_t            state, state_nxt;
   logic [CH_W-1:0]   ch_nxt, ch_inc;
   logic [1:0]        cause_nxt;
   logic [RCNT_W-1:0] cnt_nxt, cnt_inc, cnt_wdg;
   logic [NUM_CH-1:0] ch_res_n_nxt;
   logic              tmr_load, tmr_zero;
   logic [TMR_W-1:0]  tmr_val;

   reset_seq_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .sys_res  (sys_res),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   assign ch_inc  = active_ch + CH_W'(1);
   assign cnt_inc = (&reset_cnt) ? reset_cnt : reset_cnt + RCNT_W'(1);
   // A healthy-boot clear coinciding with a watchdog trigger counts that trigger.
   assign cnt_wdg = clr_cnt ? RCNT_W'(1) : cnt_inc;

   // Next-state, timer load and counter/cause updates.
   always_comb begin
      state_nxt = state;
      ch_nxt    = active_ch;
      cause_nxt = reset_cause;
      cnt_nxt   = reset_cnt;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         IDLE: begin
            if (clr_cnt) cnt_nxt = '0;
            if (wdg_to) begin
               cause_nxt = CAUSE_WDG;
               cnt_nxt   = cnt_wdg;
               ch_nxt    = '0;
               if ((MAX_RESETS > 0) && (cnt_wdg == RCNT_W'(MAX_RESETS))) begin
                  state_nxt = LOCK;
               end else begin
                  state_nxt = HOLD;
                  tmr_load  = 1'b1;
                  tmr_val   = hold_m1[0];
               end
            end else if (sw_req) begin
               cause_nxt = CAUSE_SW;
               ch_nxt    = '0;
               state_nxt = HOLD;
               tmr_load  = 1'b1;
               tmr_val   = hold_m1[0];
            end
         end
         HOLD: begin
            if (clr_cnt) cnt_nxt = '0;
            if (tmr_zero) begin
               if (active_ch == LAST_CH) begin
                  state_nxt = IDLE;
                  ch_nxt    = '0;
               end else if (PAD_CYCLES > 0) begin
                  state_nxt = PAD;
                  tmr_load  = 1'b1;
                  tmr_val   = TMR_W'(PAD_LD);
               end else begin
                  ch_nxt   = ch_inc;
                  tmr_load = 1'b1;
                  tmr_val  = hold_m1[ch_inc];
               end
            end
         end
         PAD: begin
            if (clr_cnt) cnt_nxt = '0;
            if (tmr_zero) begin
               state_nxt = HOLD;
               ch_nxt    = ch_inc;
               tmr_load  = 1'b1;
               tmr_val   = hold_m1[ch_inc];
            end
         end
         LOCK: begin
            // Only sys_res leaves lockout.
         end
         default: begin
            state_nxt = IDLE;
            ch_nxt    = '0;
         end
      endcase
   end

   // Channel reset pattern derived from the upcoming state so it can be registered.
   always_comb begin
      ch_res_n_nxt = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((state_nxt == HOLD) && (ch_nxt == CH_W'(i))) ch_res_n_nxt[i] = 1'b0;
      end
      if (state_nxt == LOCK) ch_res_n_nxt[0] = 1'b0;
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (sys_res) begin
         state       <= IDLE;
         active_ch   <= '0;
         reset_cause <= CAUSE_NONE;
         reset_cnt   <= '0;
         ch_res_n    <= '1;
         busy        <= 1'b0;
         lockout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         active_ch   <= ch_nxt;
         reset_cause <= cause_nxt;
         reset_cnt   <= cnt_nxt;
         ch_res_n    <= ch_res_n_nxt;
         busy        <= (state_nxt != IDLE);
         lockout     <= (state_nxt == LOCK);
      end
   end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default two-channel instance plus a
// three-channel back-to-back instance.
module tb_reset_seq;

   logic       clk = 1'b0;
   logic       sys_res, wdg_to, sw_req, clr_cnt;
   logic [1:0] ch_res_n;
   logic       busy, lockout;
   logic [0:0] active_ch;
   logic [1:0] reset_cause;
   logic [3:0] reset_cnt;

   logic       sys_res_b, wdg_b, sw_b, clr_b;
   logic [2:0] ch_res_n_b;
   logic       busy_b, lockout_b;
   logic [1:0] active_ch_b;
   logic [1:0] cause_b;
   logic [3:0] cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reset_seq u_dut (
      .clk         (clk),
      .sys_res     (sys_res),
      .wdg_to      (wdg_to),
      .sw_req      (sw_req),
      .clr_cnt     (clr_cnt),
      .ch_res_n    (ch_res_n),
      .busy        (busy),
      .active_ch   (active_ch),
      .reset_cause (reset_cause),
      .reset_cnt   (reset_cnt),
      .lockout     (lockout)
   );

   reset_seq #(
      .NUM_CH      (3),
      .HOLD_CYCLES ({8'd1, 8'd2, 8'd3}),
      .PAD_CYCLES  (0),
      .MAX_RESETS  (0)
   ) u_dut_b (
      .clk         (clk),
      .sys_res     (sys_res_b),
      .wdg_to      (wdg_b),
      .sw_req      (sw_b),
      .clr_cnt     (clr_b),
      .ch_res_n    (ch_res_n_b),
      .busy        (busy_b),
      .active_ch   (active_ch_b),
      .reset_cause (cause_b),
      .reset_cnt   (cnt_b),
      .lockout     (lockout_b)
   );

   typedef struct {
      logic       rst;
      logic       w;
      logic       s;
      logic       c;
      logic       seq;
      logic [1:0] cause;
      logic [3:0] cnt;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      sys_res = 1'b1;
      wdg_to = 1'b0; sw_req = 1'b0; clr_cnt = 1'b0;
      repeat (2) @(negedge clk);
      sys_res = 1'b0;
   endtask

   task automatic pulse(input logic w, input logic s, input logic c);
      wdg_to = w; sw_req = s; clr_cnt = c;
      @(posedge clk);
      #1;
      wdg_to = 1'b0; sw_req = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic pulse_b(input logic w, input logic s);
      wdg_b = w; sw_b = s;
      @(posedge clk);
      #1;
      wdg_b = 1'b0; sw_b = 1'b0;
   endtask

   // 66-cycle default sequence: ch0 low 1..60, pad 61..65, ch1 low 66, idle 67.
   // inj > 0 pulses wdg_to and sw_req at cycle inj to show they are ignored.
   task automatic prof_a(input string nm, input int inj);
      int         bad = 0;
      logic [1:0] exp_ch, got_ch;
      logic       exp_busy, got_busy;
      got_ch = '0; got_busy = 1'b0;
      for (int j = 1; j <= 67; j++) begin
         @(negedge clk);
         if (j <= 60)      exp_ch = 2'b10;
         else if (j <= 65) exp_ch = 2'b11;
         else if (j == 66) exp_ch = 2'b01;
         else              exp_ch = 2'b11;
         exp_busy = (j <= 66);
         if (bad == 0 && (ch_res_n !== exp_ch || busy !== exp_busy)) begin
            bad = j; got_ch = ch_res_n; got_busy = busy;
         end
         if (inj > 0 && j == inj)     begin wdg_to = 1'b1; sw_req = 1'b1; end
         if (inj > 0 && j == inj + 1) begin wdg_to = 1'b0; sw_req = 1'b0; end
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got ch_res_n=%b busy=%b", nm, bad, got_ch, got_busy);
      end
   endtask

   // Three-channel back-to-back: ch0 low 1..3, ch1 4..5, ch2 6, idle 7.
   task automatic prof_b(input string nm);
      int         bad = 0;
      logic [2:0] exp_ch, got_ch;
      got_ch = '0;
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         if (j <= 3)      exp_ch = 3'b110;
         else if (j <= 5) exp_ch = 3'b101;
         else if (j == 6) exp_ch = 3'b011;
         else             exp_ch = 3'b111;
         if (bad == 0 && (ch_res_n_b !== exp_ch || busy_b !== (j <= 6))) begin
            bad = j; got_ch = ch_res_n_b;
         end
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got ch_res_n=%b", nm, bad, got_ch);
      end
   endtask

   initial begin
      int lock_bad;

      sys_res = 1'b1; wdg_to = 1'b0; sw_req = 1'b0; clr_cnt = 1'b0;
      sys_res_b = 1'b1; wdg_b = 1'b0; sw_b = 1'b0; clr_b = 1'b0;

      //           rst   w     s     c     seq   cause  cnt
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 4'd1};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'd1};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'd2};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 4'd1};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 4'd0};

      repeat (2) @(negedge clk);
      chk("rst_ch_res_n", 32'(ch_res_n), 32'h3);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_active_ch", 32'(active_ch), 32'h0);
      chk("rst_cause", 32'(reset_cause), 32'h0);
      chk("rst_cnt", 32'(reset_cnt), 32'h0);
      chk("rst_lockout", 32'(lockout), 32'h0);
      sys_res = 1'b0;
      sys_res_b = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].rst) do_reset();
         pulse(vecs[v].w, vecs[v].s, vecs[v].c);
         if (vecs[v].seq) begin
            prof_a($sformatf("vec%0d_profile", v), 0);
         end else begin
            @(negedge clk);
            chk($sformatf("vec%0d_idle_busy", v), 32'(busy), 32'h0);
         end
         chk($sformatf("vec%0d_cause", v), 32'(reset_cause), 32'(vecs[v].cause));
         chk($sformatf("vec%0d_cnt", v), 32'(reset_cnt), 32'(vecs[v].cnt));
         chk($sformatf("vec%0d_lockout", v), 32'(lockout), 32'h0);
      end

      // Triggers during a sequence are dropped.
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      prof_a("ignore_mid_seq", 20);
      chk("ignore_cnt", 32'(reset_cnt), 32'h1);
      chk("ignore_cause", 32'(reset_cause), 32'h1);

      // Held watchdog restarts on the first idle cycle and escalates to lockout.
      do_reset();
      wdg_to = 1'b1;
      @(posedge clk);
      prof_a("held_seq1", 0);
      chk("held_cnt1", 32'(reset_cnt), 32'h1);
      prof_a("held_seq2", 0);
      chk("held_cnt2", 32'(reset_cnt), 32'h2);
      @(negedge clk);
      chk("lock_lockout", 32'(lockout), 32'h1);
      chk("lock_ch_res_n", 32'(ch_res_n), 32'h2);
      chk("lock_busy", 32'(busy), 32'h1);
      chk("lock_cnt", 32'(reset_cnt), 32'h3);
      chk("lock_active_ch", 32'(active_ch), 32'h0);
      wdg_to = 1'b0;
      lock_bad = 0;
      for (int j = 1; j <= 500; j++) begin
         @(negedge clk);
         if (lock_bad == 0 && (lockout !== 1'b1 || ch_res_n !== 2'b10 ||
                               busy !== 1'b1 || reset_cnt !== 4'd3)) lock_bad = j;
         clr_cnt = (j % 7 == 0);
         sw_req  = (j % 11 == 0);
         wdg_to  = (j % 13 == 0);
      end
      chk("lock_held_500", 32'(lock_bad), 32'h0);
      sys_res = 1'b1; clr_cnt = 1'b0; sw_req = 1'b0; wdg_to = 1'b0;
      @(negedge clk);
      chk("unlock_ch_res_n", 32'(ch_res_n), 32'h3);
      chk("unlock_busy", 32'(busy), 32'h0);
      chk("unlock_lockout", 32'(lockout), 32'h0);
      chk("unlock_cnt", 32'(reset_cnt), 32'h0);
      chk("unlock_cause", 32'(reset_cause), 32'h0);
      sys_res = 1'b0;
      @(negedge clk);

      // Clearing after two watchdog resets prevents lockout on the third.
      pulse(1'b1, 1'b0, 1'b0);
      prof_a("clr_seq1", 0);
      pulse(1'b1, 1'b0, 1'b0);
      prof_a("clr_seq2", 0);
      pulse(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("clr_cnt_zero", 32'(reset_cnt), 32'h0);
      pulse(1'b1, 1'b0, 1'b0);
      prof_a("clr_seq3", 0);
      chk("clr_cnt_one", 32'(reset_cnt), 32'h1);
      chk("clr_no_lockout", 32'(lockout), 32'h0);

      // Three-channel back-to-back instance.
      pulse_b(1'b0, 1'b1);
      prof_b("b_profile");
      chk("b_cause", 32'(cause_b), 32'h2);
      pulse_b(1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("b_active_ch1", 32'(active_ch_b), 32'h1);
      chk("b_ch1_low", 32'(ch_res_n_b), 32'h5);
      sys_res_b = 1'b1;
      @(negedge clk);
      chk("b_abort_ch_res_n", 32'(ch_res_n_b), 32'h7);
      chk("b_abort_busy", 32'(busy_b), 32'h0);
      sys_res_b = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         pulse_b(1'b1, 1'b0);
         repeat (7) @(negedge clk);
      end
      chk("b_nolock_cnt", 32'(cnt_b), 32'h3);
      chk("b_nolock_lockout", 32'(lockout_b), 32'h0);
      chk("b_nolock_busy", 32'(busy_b), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised N-channel reset sequencer for the watchdog subsystem. It replaces the fixed two-stage core/watchdog reset controller.
- A trigger (watchdog timeout or software request) makes it assert an active-low reset on each channel in turn, with an all-released padding gap between channels.
- It records the reset cause and counts consecutive watchdog resets. After a configurable number of them it escalates to a permanent lockout that holds channel 0 (core) in reset.
- Each ch_res_n output is AND-ed externally with the system reset before it drives a target block.

Parameters:
- NUM_CH, 2, number of reset channels. Channel 0 is released first; by convention 0 = core, 1 = watchdog.
- HOLD_W, 8, width of each per-channel hold count.
- HOLD_CYCLES, {8'd1, 8'd60}, packed NUM_CH*HOLD_W vector. Slice i is the number of cycles channel i is held in reset. Each value must be >= 1; 0 is a compile-time error.
- PAD_CYCLES, 5, released cycles between consecutive channels. 0 = back-to-back.
- RCNT_W, 4, width of the watchdog-reset counter.
- MAX_RESETS, 3, number of consecutive watchdog-triggered sequences that causes lockout. 0 disables lockout. Must be < 2^RCNT_W.

Ports:
- clk, in, 1, system clock.
- sys_res, in, 1, synchronous active-high reset.
- wdg_to, in, 1, watchdog timeout, level-sampled.
- sw_req, in, 1, software reset request, level-sampled.
- clr_cnt, in, 1, single-cycle pulse: software declares a healthy boot and clears reset_cnt.
- ch_res_n, out, NUM_CH, active-low per-channel reset.
- busy, out, 1, sequence in progress or lockout.
- active_ch, out, $clog2(NUM_CH) (min 1), index of the channel currently held or about to be held.
- reset_cause, out, 2, cause of the last sequence: 00 none, 01 watchdog, 10 software.
- reset_cnt, out, RCNT_W, consecutive watchdog-triggered sequences.
- lockout, out, 1, permanent-reset state reached.

Behaviour:
- All outputs are registered.
- Values while sys_res is high: ch_res_n all 1s, busy 0, active_ch 0, reset_cause 00, reset_cnt 0, lockout 0, state IDLE, timer 0. sys_res mid-sequence or in LOCK aborts to these values on the next edge.
- States: IDLE, HOLD, PAD, LOCK.
- IDLE: busy 0.
  - A trigger sampled high at edge k moves to HOLD with active_ch 0. ch_res_n[0] is 0 from cycle k+1.
  - Priority: wdg_to over sw_req when both are high. reset_cause is updated at the same edge.
- HOLD: ch_res_n[active_ch] = 0 for exactly HOLD_CYCLES[active_ch] cycles; all other channels are 1. After that:
  - if active_ch < NUM_CH-1 and PAD_CYCLES > 0 -> PAD;
  - if active_ch < NUM_CH-1 and PAD_CYCLES = 0 -> HOLD with active_ch+1;
  - if active_ch = NUM_CH-1 -> IDLE.
- PAD: all ch_res_n = 1 for exactly PAD_CYCLES cycles, then HOLD with active_ch+1.
- With defaults, a sequence is 60 + 5 + 1 = 66 cycles of busy.
- Triggers while busy are ignored and not queued. A trigger held high when the sequence ends starts a new sequence on the first IDLE cycle.
- reset_cnt is updated only on a watchdog-triggered IDLE->HOLD transition: it increments, saturating at all 1s.
  - A sw_req-triggered sequence leaves reset_cnt unchanged.
  - clr_cnt in any state sets reset_cnt to 0. If clr_cnt coincides with a wdg trigger, the result is 1.
- Lockout: if MAX_RESETS > 0 and a watchdog trigger makes the new reset_cnt equal MAX_RESETS, go to LOCK instead of HOLD.
  - LOCK: ch_res_n[0] = 0, all other channels 1, lockout 1, busy 1, active_ch 0.
  - LOCK is left only by sys_res; clr_cnt and triggers are ignored there.
- Timer: a single down-counter of width max(HOLD_W, $clog2(PAD_CYCLES+1)).
  - Loaded with duration-1 on entering HOLD or PAD; the state advances when it reads 0.
  - No wrap-around is possible because loads are bounded by the parameters.

Decomposition:
- Package reset_seq_pkg holds:
  - state encoding (IDLE, HOLD, PAD, LOCK);
  - cause codes CAUSE_NONE, CAUSE_WDG, CAUSE_SW;
  - a function hold_of(i) that extracts slice i of HOLD_CYCLES.
- One sub-module, reset_seq_timer: loadable down-counter with a load/value input and a zero flag. The FSM and counters stay in reset_seq.

Test Plan (defaults unless noted):
- wdg_to pulse at cycle 10 -> ch_res_n[0]=0 for cycles 11..70; all 1s for 71..75; ch_res_n[1]=0 at 76; IDLE at 77 with busy 0; reset_cause 01; reset_cnt 1.
- sw_req pulse -> same 66-cycle timing; reset_cause 10; reset_cnt unchanged. With wdg_to and sw_req high together -> reset_cause 01.
- wdg_to pulses mid-sequence (cycle 30) -> ignored, reset_cnt still 1. wdg_to held high through the end -> second sequence starts on the first IDLE cycle; reset_cnt 2.
- Three wdg sequences with no clr_cnt -> third trigger enters LOCK: ch_res_n = 2'b10, lockout 1, held for 500 cycles despite clr_cnt and sw_req. sys_res -> all reset values.
- Two wdg sequences, clr_cnt, one more wdg -> reset_cnt 1, no lockout. clr_cnt coinciding with a wdg trigger -> reset_cnt 1.
- NUM_CH=3, HOLD_CYCLES={1,2,3}, PAD_CYCLES=0 -> ch0 low 3 cycles, ch1 low 2, ch2 low 1, back-to-back. sys_res asserted during ch1 hold -> all ch_res_n 1 on the next cycle.
